uart_rx_cfg: RTL

//  Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds run-time frame format
//  (5-8 data bits, none/even/odd parity, 1/2 stop bits), per-word parity and framing error flags,
//  a show-ahead RX FIFO with a sticky overrun flag, and false-start rejection.

---
 rtl/uart_rx_cfg.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_cfg                                                   |
// | Purpose  : Configurable UART receiver. Run-time frame format (5-8 data   |
// |            bits, none/even/odd parity, 1/2 stop bits), per-word parity   |
// |            and framing flags, show-ahead RX FIFO with sticky overrun,    |
// |            false-start rejection.                                        |
// | Ports    : clk, rst (async, active high), rxd (async serial in),         |
// |            cfg_data_bits/cfg_parity/cfg_stop2 (frame format),            |
// |            rd_en/clr_ovr (FIFO pop / overrun clear),                     |
// |            rd_data/rd_perr/rd_ferr/rd_empty/rd_count (FIFO head/status), |
// |            overrun (sticky), rx_busy (receiver not idle),                |
// |            brk (only when UART_RX_BREAK_DETECT_EN is defined).           |
// | Options  : UART_RX_BREAK_DETECT_EN - break frames raise brk instead of   |
// |            being pushed into the FIFO.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_cfg #(
    parameter int CLK_FREQ     = 25000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          rd_en,
    input  logic                          clr_ovr,
    output logic [7:0]                    rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rd_count,
    output logic                          overrun,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                          brk,
`endif
    output logic                          rx_busy
);

    localparam int TCW = $clog2(OVERSAMPLING);
    localparam int AW  = $clog2(FIFO_DEPTH);

    generate
        if (OVERSAMPLING < 8 || (OVERSAMPLING & (OVERSAMPLING - 1)) != 0) begin : g_badOvs
            $error("uart_rx_cfg: OVERSAMPLING must be a power of 2 and >= 8");
        end
        if (CLK_FREQ < BAUD * OVERSAMPLING) begin : g_badClk
            $error("uart_rx_cfg: CLK_FREQ must be >= BAUD*OVERSAMPLING");
        end
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
            $error("uart_rx_cfg: FIFO_DEPTH must be a power of 2 in 2..64");
        end
    endgenerate

    localparam logic [32:0]    c_INC   = 33'(BAUD * OVERSAMPLING);
    localparam logic [32:0]    c_CLK   = 33'(CLK_FREQ);
    localparam logic [TCW-1:0] c_MID   = TCW'(OVERSAMPLING / 2 - 1);
    localparam logic [TCW-1:0] c_LAST  = TCW'(OVERSAMPLING - 1);
    localparam logic [AW:0]    c_DEPTH = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP1  = 3'd4;
    localparam logic [2:0] c_STOP2  = 3'd5;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [2:0] c_BRK    = 3'd6;
`endif

    // ---------------- oversampling tick: fractional accumulator ----------------
    logic [32:0] r_acc;
    logic [32:0] w_accSum;
    logic        r_tick;

    assign w_accSum = r_acc + c_INC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_tick <= 1'b0;
        end else if (w_accSum >= c_CLK) begin
            r_acc  <= w_accSum - c_CLK;
            r_tick <= 1'b1;
        end else begin
            r_acc  <= w_accSum;
            r_tick <= 1'b0;
        end
    end

    // ---------------- rxd synchroniser (idles high) ----------------
    logic r_rxMeta, r_rxS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
        end else begin
            r_rxMeta <= rxd;
            r_rxS    <= r_rxMeta;
        end
    end

    // ---------------- receive FSM ----------------
    logic [2:0]     r_state,    w_stateNxt;
    logic [TCW-1:0] r_tc,       w_tcNxt;
    logic [2:0]     r_bitCnt,   w_bitNxt;
    logic [7:0]     r_shift,    w_shiftNxt;
    logic           r_perr,     w_perrNxt;
    logic           r_ferr,     w_ferrNxt;
    logic [1:0]     r_cfgBits,  w_cfgBitsNxt;
    logic [1:0]     r_cfgPar,   w_cfgParNxt;
    logic           r_cfgStop2, w_cfgStop2Nxt;
    logic           r_needHigh, w_needHighNxt;
    logic           w_push, w_pushFerr;
    logic           w_bitTick, w_parEn;
    logic [2:0]     w_lastBit;
`ifdef UART_RX_BREAK_DETECT_EN
    logic           r_parBit, w_parBitNxt;
    logic           r_brk,    w_brkNxt;
`endif

    assign w_bitTick = r_tick && (r_tc == c_LAST);
    assign w_parEn   = (r_cfgPar == 2'b01) || (r_cfgPar == 2'b10);
    // Index of the final data bit: 4 + cfg (5..8 bits -> 4..7).
    assign w_lastBit = {1'b1, r_cfgBits};

    always_comb begin
        w_stateNxt    = r_state;
        w_tcNxt       = r_tick ? r_tc + 1'b1 : r_tc;
        w_bitNxt      = r_bitCnt;
        w_shiftNxt    = r_shift;
        w_perrNxt     = r_perr;
        w_ferrNxt     = r_ferr;
        w_cfgBitsNxt  = r_cfgBits;
        w_cfgParNxt   = r_cfgPar;
        w_cfgStop2Nxt = r_cfgStop2;
        w_needHighNxt = r_needHigh;
        w_push        = 1'b0;
        w_pushFerr    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        w_parBitNxt   = r_parBit;
        w_brkNxt      = r_brk;
`endif
        case (r_state)
            c_IDLE: begin
                w_tcNxt = '0;
                if (r_tick) begin
                    // After a framing error the line must be seen high once
                    // before a new start bit is accepted.
                    if (r_needHigh) begin
                        if (r_rxS) w_needHighNxt = 1'b0;
                    end else if (!r_rxS) begin
                        w_stateNxt    = c_START;
                        w_cfgBitsNxt  = cfg_data_bits;
                        w_cfgParNxt   = cfg_parity;
                        w_cfgStop2Nxt = cfg_stop2;
                        w_bitNxt      = 3'd0;
                        w_shiftNxt    = 8'd0;
                        w_perrNxt     = 1'b0;
                        w_ferrNxt     = 1'b0;
                    end
                end
            end
            c_START: begin
                if (r_tick && r_tc == c_MID) begin
                    w_tcNxt    = '0;
                    w_stateNxt = r_rxS ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_bitTick) begin
                    w_tcNxt              = '0;
                    w_shiftNxt[r_bitCnt] = r_rxS;
                    if (r_bitCnt == w_lastBit)
                        w_stateNxt = w_parEn ? c_PARITY : c_STOP1;
                    else
                        w_bitNxt = r_bitCnt + 3'd1;
                end
            end
            c_PARITY: begin
                if (w_bitTick) begin
                    w_tcNxt    = '0;
                    // cfg_parity[1] is set only for odd parity.
                    w_perrNxt  = (^r_shift ^ r_rxS) != r_cfgPar[1];
`ifdef UART_RX_BREAK_DETECT_EN
                    w_parBitNxt = r_rxS;
`endif
                    w_stateNxt = c_STOP1;
                end
            end
            c_STOP1: begin
                if (w_bitTick) begin
                    w_tcNxt   = '0;
                    w_ferrNxt = ~r_rxS;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (!r_rxS && r_shift == 8'd0 && !(w_parEn && r_parBit)) begin
                        w_stateNxt = c_BRK;
                        w_brkNxt   = 1'b1;
                    end else
`endif
                    if (r_cfgStop2) begin
                        w_stateNxt = c_STOP2;
                    end else begin
                        w_push        = 1'b1;
                        w_pushFerr    = ~r_rxS;
                        w_needHighNxt = ~r_rxS;
                        w_stateNxt    = c_IDLE;
                    end
                end
            end
            c_STOP2: begin
                if (w_bitTick) begin
                    w_tcNxt       = '0;
                    w_ferrNxt     = r_ferr | ~r_rxS;
                    w_push        = 1'b1;
                    w_pushFerr    = r_ferr | ~r_rxS;
                    w_needHighNxt = r_ferr | ~r_rxS;
                    w_stateNxt    = c_IDLE;
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            c_BRK: begin
                if (r_tick && r_rxS) begin
                    w_brkNxt   = 1'b0;
                    w_stateNxt = c_IDLE;
                end
            end
`endif
            default: w_stateNxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_tc       <= '0;
            r_bitCnt   <= 3'd0;
            r_shift    <= 8'd0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_cfgBits  <= 2'b11;
            r_cfgPar   <= 2'b00;
            r_cfgStop2 <= 1'b0;
            r_needHigh <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_parBit   <= 1'b0;
            r_brk      <= 1'b0;
`endif
        end else begin
            r_state    <= w_stateNxt;
            r_tc       <= w_tcNxt;
            r_bitCnt   <= w_bitNxt;
            r_shift    <= w_shiftNxt;
            r_perr     <= w_perrNxt;
            r_ferr     <= w_ferrNxt;
            r_cfgBits  <= w_cfgBitsNxt;
            r_cfgPar   <= w_cfgParNxt;
            r_cfgStop2 <= w_cfgStop2Nxt;
            r_needHigh <= w_needHighNxt;
`ifdef UART_RX_BREAK_DETECT_EN
            r_parBit   <= w_parBitNxt;
            r_brk      <= w_brkNxt;
`endif
        end
    end

    assign rx_busy = (r_state != c_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign brk = r_brk;
`endif

    // ---------------- show-ahead RX FIFO ----------------
    logic [7:0] r_memData [FIFO_DEPTH];
    logic       r_memPerr [FIFO_DEPTH];
    logic       r_memFerr [FIFO_DEPTH];
    logic [AW:0] r_wrPtr, r_rdPtr, w_count;
    logic        w_empty, w_full, w_pop, w_wr;

    assign w_count = r_wrPtr - r_rdPtr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == c_DEPTH);
    assign w_pop   = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_memData[r_wrPtr[AW-1:0]] <= r_shift;
            r_memPerr[r_wrPtr[AW-1:0]] <= r_perr;
            r_memFerr[r_wrPtr[AW-1:0]] <= w_pushFerr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && w_full && !w_pop)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

    // Storage is not reset; gate the head so an empty FIFO reads as zeros.
    assign rd_empty = w_empty;
    assign rd_count = w_count;
    assign rd_data  = w_empty ? 8'd0 : r_memData[r_rdPtr[AW-1:0]];
    assign rd_perr  = w_empty ? 1'b0 : r_memPerr[r_rdPtr[AW-1:0]];
    assign rd_ferr  = w_empty ? 1'b0 : r_memFerr[r_rdPtr[AW-1:0]];

endmodule
`default_nettype wire
